mag_comp_pipe: RTL and testbench
================================

MAG_COMP_PIPE -- requirements
Module: mag_comp_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..64.
REQ-002 Parameter CNT_W, default 16: width of each result counter.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair a/b/signed_mode is presented.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 signed_mode  input  1  1 = compare as two's complement; 0 = compare as unsigned; sampled with the operand pair.
REQ-010 clr  input  1  synchronous clear of all result counters.
REQ-011 out_valid  output  1  registered result is held.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 gt / lt / eq  output  1 each  registered a>b, a<b, a==b; exactly one is high while out_valid=1; all 0 while out_valid=0.
REQ-014 gt_cnt / lt_cnt / eq_cnt  output  CNT_W each  count of accepted results of each kind.

Function
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 in_ready SHALL be !out_valid || out_ready (combinational pass-through of back-pressure, single result register).
REQ-017 Latency SHALL be 1 cycle: a pair accepted on edge N is on gt/lt/eq with out_valid=1 after edge N.
REQ-018 Accept and drain in the same cycle SHALL load the new result; out_valid stays 1 with no bubble; throughput 1 pair/cycle.
REQ-019 Without input transfer, output transfer SHALL clear out_valid and gt/lt/eq.
REQ-020 Without output transfer, out_valid, gt, lt, eq SHALL hold stable, regardless of changes on a, b, signed_mode.
REQ-021 Outputs SHALL never be X or Z; every output is a defined 0/1 value at all times after reset.
REQ-022 Signed comparison SHALL treat bit WIDTH-1 as sign; unsigned SHALL treat all bits as magnitude; eq is identical in both modes.
REQ-023 On each input transfer, exactly one of gt_cnt/lt_cnt/eq_cnt SHALL increment by 1, visible the cycle after the transfer.
REQ-024 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-025 clr=1 SHALL set all three counters to 0 on the next edge; if an input transfer occurs in the same cycle, clr wins (counters = 0); the result register is unaffected by clr.
REQ-026 clr SHALL not affect in_ready, out_valid or gt/lt/eq.

Reset
REQ-027 rst_n=0 SHALL immediately force out_valid=0, gt=lt=eq=0, all counters=0, independent of clk.
REQ-028 A result held when reset asserts SHALL be discarded; after deassertion in_ready=1 and the first accepted pair behaves per REQ-017.
REQ-029 rst_n deassertion is synchronised externally; the block has no internal reset synchroniser.

Structure
REQ-030 Shared package mag_comp_pkg SHALL hold the 2-bit result encoding (RES_EQ=0, RES_LT=1, RES_GT=2) and the default WIDTH/CNT_W constants.
REQ-031 Sub-module mag_comp_core SHALL be the purely combinational WIDTH-parametrised compare (a, b, signed_mode -> encoded result); mag_comp_pipe holds the registers, handshake and counters.

Verification
REQ-032 WIDTH=8, unsigned: a=0x80, b=0x7F -> gt=1 one cycle later, gt_cnt=1; same pair with signed_mode=1 -> lt=1, lt_cnt=1.
REQ-033 Back-pressure: out_ready=0 with result held, in_valid=1 new pair -> in_ready=0, outputs unchanged for 5 cycles; out_ready=1 -> new pair accepted same cycle, no bubble.
REQ-034 Streaming: 100 back-to-back pairs with out_ready=1 -> 100 results on 100 consecutive cycles; gt_cnt+lt_cnt+eq_cnt=100.
REQ-035 Saturation: CNT_W=4, 20 equal pairs -> eq_cnt stops at 15; clr with simultaneous accept -> all counters 0 next cycle.
REQ-036 Reset mid-operation: rst_n=0 asynchronously while out_valid=1 and eq_cnt=7 -> out_valid=0, all counters 0 before the next clk edge.
REQ-037 Boundary: WIDTH=2 signed, a=2'b10, b=2'b01 -> lt=1; a=b=0 -> eq=1; no X on any output throughout.

Source files
------------

// File: rtl/mag_comp_pkg.sv
// Shared definitions for the magnitude-compare pipeline: the 2-bit result
// encoding, its decode to one-hot flags, and the default widths.
package mag_comp_pkg;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_LT = 2'd1,
        RES_GT = 2'd2
    } res_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } flags_t;

    // Code 3 is never produced by the core; it falls into the eq arm so the
    // decoded flags stay one-hot under any encoding.
    function automatic flags_t decode_res(input res_e r);
        flags_t f;
        f = '0;
        case (r)
            RES_GT:  f.gt = 1'b1;
            RES_LT:  f.lt = 1'b1;
            default: f.eq = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mag_comp_core.sv
// Purely combinational WIDTH-bit magnitude compare, signed or unsigned,
// producing the shared 2-bit result encoding.
module mag_comp_core
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic [1:0]       res
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;

    // One guard bit: sign-extend in signed mode, zero-extend otherwise, so a
    // single signed comparator serves both modes.
    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};

    always_comb begin
        res = RES_EQ;
        if (a_ext > b_ext) begin
            res = RES_GT;
        end else if (a_ext < b_ext) begin
            res = RES_LT;
        end
    end

endmodule

// File: rtl/mag_comp_pipe.sv
// Single-register valid/ready compare stage with saturating per-result
// counters; the compare itself lives in mag_comp_core.
module mag_comp_pipe
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic             en);
        return (en && !(&v)) ? v + CNT_ONE : v;
    endfunction

    logic [1:0]       core_res;
    flags_t           core_flags;
    logic             in_xfer;
    logic             out_xfer;

    logic             out_valid_q, out_valid_d;
    flags_t           flags_q, flags_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

    mag_comp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .res         (core_res)
    );

    assign core_flags = decode_res(res_e'(core_res));

    // Back-pressure passes straight through: the single slot frees up in the
    // same cycle the consumer takes it.
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            flags_d     = core_flags;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            flags_d     = '0;
        end
    end

    // clr takes priority over a simultaneous accept.
    always_comb begin
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        if (clr) begin
            gt_cnt_d = '0;
            lt_cnt_d = '0;
            eq_cnt_d = '0;
        end else if (in_xfer) begin
            gt_cnt_d = sat_inc(gt_cnt_q, core_flags.gt);
            lt_cnt_d = sat_inc(lt_cnt_q, core_flags.lt);
            eq_cnt_d = sat_inc(eq_cnt_q, core_flags.eq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            gt_cnt_q    <= '0;
            lt_cnt_q    <= '0;
            eq_cnt_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            gt_cnt_q    <= gt_cnt_d;
            lt_cnt_q    <= lt_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign gt        = flags_q.gt;
    assign lt        = flags_q.lt;
    assign eq        = flags_q.eq;
    assign gt_cnt    = gt_cnt_q;
    assign lt_cnt    = lt_cnt_q;
    assign eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_mag_comp_pipe.sv
// Bench for mag_comp_pipe: three instances (8/16, 8/4 for saturation, 2/16 for
// the narrow signed boundary) checked against an arithmetic reference model.
module tb_mag_comp_pipe;

    logic clk;
    logic rst_n;

    logic       m_iv, m_ir, m_sm, m_clr, m_ov, m_ordy, m_gt, m_lt, m_eq;
    logic [7:0] m_a, m_b;
    logic [15:0] m_gtc, m_ltc, m_eqc;

    logic       s_iv, s_ir, s_sm, s_clr, s_ov, s_ordy, s_gt, s_lt, s_eq;
    logic [7:0] s_a, s_b;
    logic [3:0] s_gtc, s_ltc, s_eqc;

    logic       n_iv, n_ir, n_sm, n_clr, n_ov, n_ordy, n_gt, n_lt, n_eq;
    logic [1:0] n_a, n_b;
    logic [15:0] n_gtc, n_ltc, n_eqc;

    int n_tests;
    int n_fail;

    // Reference state per instance: 0 = main, 1 = saturating, 2 = narrow.
    // Counter index: 0 = gt, 1 = lt, 2 = eq.
    bit e_v [3];
    bit e_g [3];
    bit e_l [3];
    bit e_e [3];
    int e_cnt [3][3];

    mag_comp_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir),
        .a(m_a), .b(m_b), .signed_mode(m_sm), .clr(m_clr),
        .out_valid(m_ov), .out_ready(m_ordy), .gt(m_gt), .lt(m_lt), .eq(m_eq),
        .gt_cnt(m_gtc), .lt_cnt(m_ltc), .eq_cnt(m_eqc)
    );

    mag_comp_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir),
        .a(s_a), .b(s_b), .signed_mode(s_sm), .clr(s_clr),
        .out_valid(s_ov), .out_ready(s_ordy), .gt(s_gt), .lt(s_lt), .eq(s_eq),
        .gt_cnt(s_gtc), .lt_cnt(s_ltc), .eq_cnt(s_eqc)
    );

    mag_comp_pipe #(.WIDTH(2), .CNT_W(16)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_iv), .in_ready(n_ir),
        .a(n_a), .b(n_b), .signed_mode(n_sm), .clr(n_clr),
        .out_valid(n_ov), .out_ready(n_ordy), .gt(n_gt), .lt(n_lt), .eq(n_eq),
        .gt_cnt(n_gtc), .lt_cnt(n_ltc), .eq_cnt(n_eqc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Numeric comparison from first principles: 0 = gt, 1 = lt, 2 = eq.
    function automatic int ref_cmp(input longint ia, input longint ib,
                                   input bit sm, input int w);
        longint x;
        longint y;
        x = ia;
        y = ib;
        if (sm && x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        if (sm && y >= (64'sd1 <<< (w - 1))) y = y - (64'sd1 <<< w);
        if (x > y) return 0;
        if (x < y) return 1;
        return 2;
    endfunction

    task automatic model_edge(input int d, input bit iv, input longint ia,
                              input longint ib, input bit sm, input bit ordy,
                              input bit iclr, input int w, input int cw);
        bit acc;
        bit drn;
        int k;
        acc = iv && (!e_v[d] || ordy);
        drn = e_v[d] && ordy;
        k   = ref_cmp(ia, ib, sm, w);
        if (iclr) begin
            for (int j = 0; j < 3; j++) e_cnt[d][j] = 0;
        end else if (acc && e_cnt[d][k] < (1 << cw) - 1) begin
            e_cnt[d][k] = e_cnt[d][k] + 1;
        end
        if (acc) begin
            e_v[d] = 1'b1;
            e_g[d] = (k == 0);
            e_l[d] = (k == 1);
            e_e[d] = (k == 2);
        end else if (drn) begin
            e_v[d] = 1'b0;
            e_g[d] = 1'b0;
            e_l[d] = 1'b0;
            e_e[d] = 1'b0;
        end
    endtask

    task automatic model_reset;
        for (int d = 0; d < 3; d++) begin
            e_v[d] = 0; e_g[d] = 0; e_l[d] = 0; e_e[d] = 0;
            for (int j = 0; j < 3; j++) e_cnt[d][j] = 0;
        end
    endtask

    function automatic logic [3:0] exp_flags(input int d);
        return {e_v[d], e_g[d], e_l[d], e_e[d]};
    endfunction

    function automatic logic [47:0] exp_cnt(input int d);
        return {16'(e_cnt[d][0]), 16'(e_cnt[d][1]), 16'(e_cnt[d][2])};
    endfunction

    // Advance one clock with the model stepped on the current inputs; ends on
    // the falling edge so outputs are sampled away from the active edge.
    task automatic tick;
        model_edge(0, m_iv, m_a, m_b, m_sm, m_ordy, m_clr, 8, 16);
        model_edge(1, s_iv, s_a, s_b, s_sm, s_ordy, s_clr, 8, 4);
        model_edge(2, n_iv, n_a, n_b, n_sm, n_ordy, n_clr, 2, 16);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000", {m_ov, m_gt, m_lt, m_eq});
        end
        n_tests++;
        if ({m_gtc, m_ltc, m_eqc} !== 48'd0) begin
            n_fail++; $display("FAIL reset_cnt got %h exp 0", {m_gtc, m_ltc, m_eqc});
        end
        n_tests++;
        if (m_ir !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b exp 1", m_ir);
        end
        n_tests++;
        if ({s_ov, s_gt, s_lt, s_eq, s_gtc, s_ltc, s_eqc, n_ov, n_gt, n_lt, n_eq, n_gtc, n_ltc, n_eqc} !== '0) begin
            n_fail++; $display("FAIL reset_other got sat=%b%b%b%b narrow=%b%b%b%b exp all 0",
                               s_ov, s_gt, s_lt, s_eq, n_ov, n_gt, n_lt, n_eq);
        end
    endtask

    task automatic test_directed;
        m_iv = 1; m_a = 8'h80; m_b = 8'h7F; m_sm = 0; m_ordy = 1;
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_gtc} !== {4'b1100, 16'd1}) begin
            n_fail++; $display("FAIL dir_unsigned got %b cnt %0d exp 1100 cnt 1", {m_ov, m_gt, m_lt, m_eq}, m_gtc);
        end
        m_sm = 1;
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_ltc} !== {4'b1010, 16'd1}) begin
            n_fail++; $display("FAIL dir_signed got %b cnt %0d exp 1010 cnt 1", {m_ov, m_gt, m_lt, m_eq}, m_ltc);
        end
        m_iv = 0;
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_gtc, m_ltc, m_eqc} !== {4'b0000, 16'd1, 16'd1, 16'd0}) begin
            n_fail++; $display("FAIL dir_drain got %b %0d/%0d/%0d exp 0000 1/1/0",
                               {m_ov, m_gt, m_lt, m_eq}, m_gtc, m_ltc, m_eqc);
        end
    endtask

    task automatic test_backpressure;
        m_iv = 1; m_a = 8'd5; m_b = 8'd9; m_sm = 0; m_ordy = 0;
        tick;
        for (int i = 0; i < 5; i++) begin
            m_a = 8'($urandom); m_b = 8'($urandom); m_sm = 1'($urandom);
            #1;
            n_tests++;
            if (m_ir !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", i, m_ir);
            end
            tick;
            n_tests++;
            if ({m_ov, m_gt, m_lt, m_eq} !== 4'b1010 || {m_gtc, m_ltc, m_eqc} !== exp_cnt(0)) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got %b exp 1010", i, {m_ov, m_gt, m_lt, m_eq});
            end
        end
        m_a = 8'd9; m_b = 8'd5; m_sm = 0; m_ordy = 1;
        #1;
        n_tests++;
        if (m_ir !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got %b exp 1", m_ir);
        end
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq} !== 4'b1100 || {m_gtc, m_ltc, m_eqc} !== exp_cnt(0)) begin
            n_fail++; $display("FAIL bp_release got %b exp 1100", {m_ov, m_gt, m_lt, m_eq});
        end
        m_iv = 0;
        tick;
    endtask

    task automatic test_stream;
        int seen;
        m_clr = 1;
        tick;
        m_clr = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            m_iv = 1; m_ordy = 1;
            m_a = 8'($urandom); m_b = (i % 7 == 0) ? m_a : 8'($urandom); m_sm = 1'($urandom);
            tick;
            if (m_ov === 1'b1) seen++;
            n_tests++;
            if ({m_ov, m_gt, m_lt, m_eq} !== exp_flags(0)) begin
                n_fail++; $display("FAIL stream_res %0d got %b exp %b", i, {m_ov, m_gt, m_lt, m_eq}, exp_flags(0));
            end
        end
        n_tests++;
        if (seen != 100) begin
            n_fail++; $display("FAIL stream_consecutive got %0d exp 100", seen);
        end
        n_tests++;
        if (32'(m_gtc) + 32'(m_ltc) + 32'(m_eqc) != 100 || {m_gtc, m_ltc, m_eqc} !== exp_cnt(0)) begin
            n_fail++; $display("FAIL stream_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", m_gtc, m_ltc, m_eqc,
                               e_cnt[0][0], e_cnt[0][1], e_cnt[0][2]);
        end
        m_iv = 0;
        tick;
    endtask

    task automatic test_random_mix;
        for (int i = 0; i < 300; i++) begin
            m_iv = 1'($urandom); m_ordy = 1'($urandom); m_clr = ($urandom_range(15) == 0);
            m_a = 8'($urandom); m_b = ($urandom_range(3) == 0) ? m_a : 8'($urandom); m_sm = 1'($urandom);
            #1;
            n_tests++;
            if (m_ir !== (!e_v[0] || m_ordy)) begin
                n_fail++; $display("FAIL mix_in_ready %0d got %b exp %b", i, m_ir, !e_v[0] || m_ordy);
            end
            tick;
            n_tests++;
            if ({m_ov, m_gt, m_lt, m_eq} !== exp_flags(0) || {m_gtc, m_ltc, m_eqc} !== exp_cnt(0)
                || $isunknown({m_ir, m_ov, m_gt, m_lt, m_eq, m_gtc, m_ltc, m_eqc})) begin
                n_fail++; $display("FAIL mix_state %0d got %b %0d/%0d/%0d exp %b %0d/%0d/%0d", i,
                                   {m_ov, m_gt, m_lt, m_eq}, m_gtc, m_ltc, m_eqc, exp_flags(0),
                                   e_cnt[0][0], e_cnt[0][1], e_cnt[0][2]);
            end
        end
        m_clr = 0; m_iv = 0; m_ordy = 1;
        tick;
    endtask

    task automatic test_clr_accept;
        m_clr = 1; m_iv = 1; m_ordy = 1; m_a = 8'd3; m_b = 8'd3; m_sm = 0;
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_gtc, m_ltc, m_eqc} !== {4'b1001, 48'd0}) begin
            n_fail++; $display("FAIL clr_accept got %b %0d/%0d/%0d exp 1001 0/0/0",
                               {m_ov, m_gt, m_lt, m_eq}, m_gtc, m_ltc, m_eqc);
        end
        m_clr = 0; m_iv = 0;
        tick;
    endtask

    task automatic test_saturation;
        logic [7:0] v;
        s_ordy = 1; s_sm = 0;
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom);
            s_iv = 1; s_a = v; s_b = v;
            tick;
            n_tests++;
            if ({s_ov, s_gt, s_lt, s_eq} !== 4'b1001 || s_eqc !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                n_fail++; $display("FAIL sat_eq %0d got %b cnt %0d exp 1001 cnt %0d", i,
                                   {s_ov, s_gt, s_lt, s_eq}, s_eqc, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        s_clr = 1; s_a = 8'd1; s_b = 8'd2;
        tick;
        n_tests++;
        if ({s_ov, s_gt, s_lt, s_eq, s_gtc, s_ltc, s_eqc} !== {4'b1010, 12'd0}) begin
            n_fail++; $display("FAIL sat_clr got %b %0d/%0d/%0d exp 1010 0/0/0",
                               {s_ov, s_gt, s_lt, s_eq}, s_gtc, s_ltc, s_eqc);
        end
        s_clr = 0;
        tick;
        n_tests++;
        if (s_ltc !== 4'd1 || s_eqc !== 4'd0) begin
            n_fail++; $display("FAIL sat_resume got lt %0d eq %0d exp lt 1 eq 0", s_ltc, s_eqc);
        end
        s_iv = 0;
        tick;
    endtask

    task automatic test_width2;
        n_ordy = 1; n_iv = 1; n_sm = 1; n_a = 2'b10; n_b = 2'b01;
        tick;
        n_tests++;
        if ({n_ov, n_gt, n_lt, n_eq} !== 4'b1010) begin
            n_fail++; $display("FAIL w2_neg got %b exp 1010", {n_ov, n_gt, n_lt, n_eq});
        end
        n_a = 2'b00; n_b = 2'b00;
        tick;
        n_tests++;
        if ({n_ov, n_gt, n_lt, n_eq} !== 4'b1001) begin
            n_fail++; $display("FAIL w2_zero got %b exp 1001", {n_ov, n_gt, n_lt, n_eq});
        end
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    n_sm = 1'(s); n_a = 2'(x); n_b = 2'(y);
                    tick;
                    n_tests++;
                    if ({n_ov, n_gt, n_lt, n_eq} !== exp_flags(2) || {n_gtc, n_ltc, n_eqc} !== exp_cnt(2)
                        || $isunknown({n_ir, n_ov, n_gt, n_lt, n_eq, n_gtc, n_ltc, n_eqc})) begin
                        n_fail++; $display("FAIL w2_sweep sm=%0d a=%0d b=%0d got %b exp %b", s, x, y,
                                           {n_ov, n_gt, n_lt, n_eq}, exp_flags(2));
                    end
                end
            end
        end
        n_iv = 0;
        tick;
    endtask

    task automatic test_async_reset;
        m_clr = 1;
        tick;
        m_clr = 0; m_iv = 1; m_ordy = 1; m_sm = 0;
        for (int i = 0; i < 7; i++) begin
            m_a = 8'($urandom); m_b = m_a;
            tick;
        end
        m_iv = 0; m_ordy = 0;
        tick;
        n_tests++;
        if (m_ov !== 1'b1 || m_eqc !== 16'd7) begin
            n_fail++; $display("FAIL areset_pre got valid %b eq_cnt %0d exp 1 7", m_ov, m_eqc);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_gtc, m_ltc, m_eqc} !== 52'd0) begin
            n_fail++; $display("FAIL areset_async got %b %0d/%0d/%0d exp 0000 0/0/0",
                               {m_ov, m_gt, m_lt, m_eq}, m_gtc, m_ltc, m_eqc);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        n_tests++;
        if (m_ir !== 1'b1 || m_ov !== 1'b0) begin
            n_fail++; $display("FAIL areset_after got ready %b valid %b exp 1 0", m_ir, m_ov);
        end
        m_iv = 1; m_a = 8'd1; m_b = 8'd0;
        tick;
        n_tests++;
        if ({m_ov, m_gt, m_lt, m_eq, m_gtc, m_ltc, m_eqc} !== {4'b1100, 16'd1, 32'd0}) begin
            n_fail++; $display("FAIL areset_first got %b %0d/%0d/%0d exp 1100 1/0/0",
                               {m_ov, m_gt, m_lt, m_eq}, m_gtc, m_ltc, m_eqc);
        end
        m_iv = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 0;
        m_iv = 0; m_a = 0; m_b = 0; m_sm = 0; m_clr = 0; m_ordy = 1;
        s_iv = 0; s_a = 0; s_b = 0; s_sm = 0; s_clr = 0; s_ordy = 1;
        n_iv = 0; n_a = 0; n_b = 0; n_sm = 0; n_clr = 0; n_ordy = 1;
        model_reset();
        #1;
        test_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_random_mix();
        test_clr_accept();
        test_saturation();
        test_width2();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
